// File: rtl/panel_pkg.sv
// Shared definitions for the debug front panel: phase encodings, controller
// states and the command codes carried from request arbitration to issue.
package panel_pkg;

    localparam logic [3:0] PH_IF = 4'b0001;
    localparam logic [3:0] PH_DE = 4'b0010;
    localparam logic [3:0] PH_EX = 4'b0100;
    localparam logic [3:0] PH_WB = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CONFIRM,
        ST_STEP,
        ST_RUN
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_RUN,
        CMD_STEP_INST,
        CMD_STEP_PHASE
    } cmd_t;

    // Last CONFIRM cycle (counted from 0) before the acknowledge is declared lost.
    localparam logic [1:0] CONFIRM_LAST = 2'd2;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stable-level debouncer and one-cycle rising-edge
// strobe for a single raw push button.
module btn_debounce #(
    parameter logic [15:0] DB_COUNT = 16'd50000,
    parameter int unsigned DB_WIDTH = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_COUNT - 16'd1);

    logic                sync1;
    logic                sync2;
    logic                level;
    logic [DB_WIDTH-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            rise  <= 1'b0;
            // Any cycle agreeing with the accepted level restarts the count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                level <= sync2;
                cnt   <= '0;
                rise  <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/panel_ctrl.sv
// Front-panel controller: arbitrates debounced run/step requests into single
// command pulses, confirms them against the phase generator, handles breakpoints.
module panel_ctrl
    import panel_pkg::*;
#(
    parameter logic [15:0] DB_COUNT = 16'd50000,
    parameter int unsigned DB_WIDTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_run,
    input  logic        btn_step_inst,
    input  logic        btn_step_phase,
    input  logic        running,
    input  logic [3:0]  cstate,
    input  logic [31:0] pc,
    input  logic [31:0] bp_addr,
    input  logic        bp_en,
    output logic        run,
    output logic        step_inst,
    output logic        step_phase,
    output logic        bp_hit,
    output logic        err
);

    logic rise_run, rise_inst, rise_phase;

    btn_debounce #(.DB_COUNT(DB_COUNT), .DB_WIDTH(DB_WIDTH)) u_db_run (
        .clock(clock), .reset(reset), .btn(btn_run), .rise(rise_run)
    );
    btn_debounce #(.DB_COUNT(DB_COUNT), .DB_WIDTH(DB_WIDTH)) u_db_inst (
        .clock(clock), .reset(reset), .btn(btn_step_inst), .rise(rise_inst)
    );
    btn_debounce #(.DB_COUNT(DB_COUNT), .DB_WIDTH(DB_WIDTH)) u_db_phase (
        .clock(clock), .reset(reset), .btn(btn_step_phase), .rise(rise_phase)
    );

    state_t     state, state_d;
    cmd_t       cmd, cmd_d;
    logic       start, start_d;
    logic [1:0] tmo;
    logic       pend_run, pend_inst, pend_phase;
    logic       pend_run_d, pend_inst_d, pend_phase_d;
    logic       armed_off;
    logic       err_set;

    logic req_run, req_inst, req_phase, bp_match, issue_start;

    assign req_run     = pend_run | rise_run;
    assign req_inst    = pend_inst | rise_inst;
    assign req_phase   = pend_phase | rise_phase;
    assign bp_match    = (state == ST_RUN) && bp_en && (cstate == PH_IF) &&
                         (pc == bp_addr) && !armed_off;
    assign issue_start = (state == ST_ISSUE) && start;

    assign run        = (state == ST_ISSUE) && (cmd == CMD_RUN);
    assign step_inst  = (state == ST_ISSUE) && (cmd == CMD_STEP_INST);
    assign step_phase = (state == ST_ISSUE) && (cmd == CMD_STEP_PHASE);

    always_comb begin
        state_d      = state;
        cmd_d        = cmd;
        start_d      = start;
        err_set      = 1'b0;
        pend_run_d   = req_run;
        pend_inst_d  = req_inst;
        pend_phase_d = req_phase;
        case (state)
            ST_IDLE: begin
                // Highest-priority request is issued, the rest are dropped.
                pend_run_d   = 1'b0;
                pend_inst_d  = 1'b0;
                pend_phase_d = 1'b0;
                if (req_run) begin
                    cmd_d   = CMD_RUN;
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end else if (req_inst) begin
                    cmd_d   = CMD_STEP_INST;
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end else if (req_phase) begin
                    cmd_d   = CMD_STEP_PHASE;
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_CONFIRM;
            ST_CONFIRM: begin
                pend_run_d   = pend_run;
                pend_inst_d  = pend_inst;
                pend_phase_d = pend_phase;
                if (start && running) begin
                    state_d = (cmd == CMD_RUN) ? ST_RUN : ST_STEP;
                end else if (!start && !running) begin
                    state_d = ST_IDLE;
                end else if (tmo == CONFIRM_LAST) begin
                    err_set = 1'b1;
                    state_d = running ? ST_RUN : ST_IDLE;
                end
            end
            ST_STEP: begin
                pend_run_d   = pend_run;
                pend_inst_d  = pend_inst;
                pend_phase_d = pend_phase;
                if (!running) state_d = ST_IDLE;
            end
            ST_RUN: begin
                pend_run_d   = 1'b0;
                pend_inst_d  = 1'b0;
                pend_phase_d = 1'b0;
                if (req_run || bp_match) begin
                    cmd_d   = CMD_RUN;
                    start_d = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            cmd        <= CMD_NONE;
            start      <= 1'b0;
            tmo        <= '0;
            pend_run   <= 1'b0;
            pend_inst  <= 1'b0;
            pend_phase <= 1'b0;
            bp_hit     <= 1'b0;
            err        <= 1'b0;
            armed_off  <= 1'b0;
        end else begin
            state      <= state_d;
            cmd        <= cmd_d;
            start      <= start_d;
            tmo        <= (state == ST_CONFIRM) ? tmo + 2'd1 : '0;
            pend_run   <= pend_run_d;
            pend_inst  <= pend_inst_d;
            pend_phase <= pend_phase_d;
            err        <= err | err_set;
            // A start issued at the breakpoint must not re-trigger before leaving IF.
            if (issue_start) begin
                bp_hit    <= 1'b0;
                armed_off <= 1'b1;
            end else begin
                if (bp_match) bp_hit <= 1'b1;
                if (cstate != PH_IF) armed_off <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_panel_ctrl.sv
// Bench for panel_ctrl with a behavioural phase generator and a pulse scoreboard.
module tb_panel_ctrl;
    import panel_pkg::*;

    logic        clock;
    logic        reset;
    logic        btn_run, btn_step_inst, btn_step_phase;
    logic        running;
    logic [3:0]  cstate;
    logic [31:0] pc;
    logic [31:0] bp_addr;
    logic        bp_en;
    logic        run, step_inst, step_phase, bp_hit, err;

    panel_ctrl #(.DB_COUNT(16'd4), .DB_WIDTH(16)) dut (
        .clock(clock), .reset(reset),
        .btn_run(btn_run), .btn_step_inst(btn_step_inst), .btn_step_phase(btn_step_phase),
        .running(running), .cstate(cstate), .pc(pc),
        .bp_addr(bp_addr), .bp_en(bp_en),
        .run(run), .step_inst(step_inst), .step_phase(step_phase),
        .bp_hit(bp_hit), .err(err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int press_cyc = 0;
    int last_pulse_cyc = 0;
    int err_rise_cyc = -1;
    logic err_prev = 1'b0;
    cmd_t mon_got;
    cmd_t exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    // Phase generator model: 0 stopped, 1 continuous (2 cycles per phase),
    // 2 one instruction, 3 one phase.
    int          m_mode;
    logic        m_half;
    logic        ignore_inst;
    logic [3:0]  nx_cstate;
    logic [31:0] nx_pc;
    assign nx_cstate = {cstate[2:0], cstate[3]};
    assign nx_pc     = (cstate == PH_WB) ? ((pc + 32'd4) & 32'h1F) : pc;

    always @(posedge clock) begin
        if (reset) begin
            m_mode <= 0; running <= 1'b0; cstate <= PH_IF; pc <= '0; m_half <= 1'b0;
        end else if (run && m_mode == 1) begin
            m_mode <= 0; running <= 1'b0; m_half <= 1'b0;
        end else if (run && m_mode == 0) begin
            m_mode <= 1; running <= 1'b1; m_half <= 1'b0;
        end else if (step_inst && m_mode == 0 && !ignore_inst) begin
            m_mode <= 2; running <= 1'b1;
        end else if (step_phase && m_mode == 0) begin
            m_mode <= 3; running <= 1'b1;
        end else if (m_mode == 1) begin
            m_half <= !m_half;
            if (m_half) begin cstate <= nx_cstate; pc <= nx_pc; end
        end else if (m_mode == 2) begin
            cstate <= nx_cstate; pc <= nx_pc;
            if (cstate == PH_WB) begin m_mode <= 0; running <= 1'b0; end
        end else if (m_mode == 3) begin
            cstate <= nx_cstate; pc <= nx_pc; m_mode <= 0; running <= 1'b0;
        end
    end

    // Scoreboard: every command pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (reset) begin
            err_prev = 1'b0;
        end else begin
            if (err && !err_prev) err_rise_cyc = cyc;
            err_prev = err;
            if (run || step_inst || step_phase) begin
                check("pulse_exclusive", int'(run) + int'(step_inst) + int'(step_phase), 1);
                mon_got = run ? CMD_RUN : (step_inst ? CMD_STEP_INST : CMD_STEP_PHASE);
                last_pulse_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse got=%0d required=none", int'(mon_got));
                end else begin
                    check("pulse_cmd", int'(mon_got), int'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic press(input logic [2:0] mask, input int hold);
        @(negedge clock);
        {btn_run, btn_step_inst, btn_step_phase} = mask;
        press_cyc = cyc;
        repeat (hold) @(negedge clock);
        {btn_run, btn_step_inst, btn_step_phase} = 3'b000;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_empty(input string name, input int bound);
        for (int k = 0; k < bound && exp_q.size() != 0; k++) @(negedge clock);
        check(name, exp_q.size(), 0);
    endtask

    typedef struct {
        logic [2:0] mask;        // {run, step_inst, step_phase}
        cmd_t       exp;
        logic       exp_running;
        logic       check_if;
    } vec_t;

    vec_t vecs[6];
    int   k;
    int   resume_cyc;

    initial begin
        vecs[0] = '{3'b010, CMD_STEP_INST,  1'b0, 1'b1};
        vecs[1] = '{3'b001, CMD_STEP_PHASE, 1'b0, 1'b0};
        vecs[2] = '{3'b101, CMD_RUN,        1'b1, 1'b0};
        vecs[3] = '{3'b011, CMD_STEP_INST,  1'b0, 1'b1};
        vecs[4] = '{3'b111, CMD_RUN,        1'b1, 1'b0};
        vecs[5] = '{3'b100, CMD_RUN,        1'b1, 1'b0};

        reset = 1'b1;
        {btn_run, btn_step_inst, btn_step_phase} = 3'b000;
        bp_en = 1'b0;
        bp_addr = '0;
        ignore_inst = 1'b0;
        settle(3);
        check("reset_run", run, 0);
        check("reset_step_inst", step_inst, 0);
        check("reset_step_phase", step_phase, 0);
        check("reset_bp_hit", bp_hit, 0);
        check("reset_err", err, 0);
        reset = 1'b0;
        settle(2);

        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].exp);
            press(vecs[i].mask, 10);
            settle(30);
            check($sformatf("row%0d_pulse_seen", i), exp_q.size(), 0);
            check($sformatf("row%0d_running", i), running, vecs[i].exp_running);
            if (i == 0)
                check("step_latency_6_to_7", int'((last_pulse_cyc - press_cyc) inside {6, 7}), 1);
            if (vecs[i].check_if)
                check($sformatf("row%0d_back_in_if", i), cstate, PH_IF);
            if (vecs[i].exp_running) begin
                exp_q.push_back(CMD_RUN);
                press(3'b100, 10);
                settle(30);
                check($sformatf("row%0d_stop_seen", i), exp_q.size(), 0);
                check($sformatf("row%0d_stopped", i), running, 0);
            end
        end

        // Step requests while running are dropped, not deferred.
        exp_q.push_back(CMD_RUN);
        press(3'b100, 10);
        settle(25);
        press(3'b010, 10);
        settle(25);
        check("step_in_run_still_running", running, 1);
        exp_q.push_back(CMD_RUN);
        press(3'b100, 10);
        settle(40);
        check("step_in_run_stop_seen", exp_q.size(), 0);

        // Bouncing contact: 2 cycles high / 2 low for 20 cycles, then held.
        exp_q.push_back(CMD_STEP_PHASE);
        for (int b = 0; b < 5; b++) begin
            @(negedge clock); btn_step_phase = 1'b1;
            @(negedge clock);
            @(negedge clock); btn_step_phase = 1'b0;
            @(negedge clock);
        end
        press(3'b001, 10);
        settle(30);
        check("bounce_single_pulse", exp_q.size(), 0);

        // Lost acknowledge: err four cycles after the pulse, controller stays usable.
        ignore_inst = 1'b1;
        exp_q.push_back(CMD_STEP_INST);
        press(3'b010, 10);
        settle(20);
        check("ack_lost_pulse_seen", exp_q.size(), 0);
        check("ack_lost_err", err, 1);
        check("ack_lost_err_delay", err_rise_cyc - last_pulse_cyc, 4);
        ignore_inst = 1'b0;
        exp_q.push_back(CMD_STEP_PHASE);
        press(3'b001, 10);
        settle(30);
        check("after_err_phase_issued", exp_q.size(), 0);
        check("err_sticky", err, 1);

        // Reset in RUN, landing on the cycle a stop pulse would have been issued.
        exp_q.push_back(CMD_RUN);
        press(3'b100, 10);
        settle(25);
        check("pre_reset_running", running, 1);
        @(negedge clock);
        btn_run = 1'b1;
        repeat (6) @(negedge clock);
        reset = 1'b1;
        btn_run = 1'b0;
        @(negedge clock);
        check("mid_reset_run", run, 0);
        check("mid_reset_step_inst", step_inst, 0);
        check("mid_reset_step_phase", step_phase, 0);
        check("mid_reset_bp_hit", bp_hit, 0);
        check("mid_reset_err", err, 0);
        reset = 1'b0;
        settle(30);
        check("post_reset_no_pending", exp_q.size(), 0);

        // Breakpoint at 0x10, then resume from it.
        bp_en = 1'b1;
        bp_addr = 32'h0000_0010;
        exp_q.push_back(CMD_RUN);
        press(3'b100, 10);
        wait_empty("bp_start_seen", 20);
        exp_q.push_back(CMD_RUN);
        k = 0;
        while (!bp_hit && k < 150) begin @(negedge clock); k++; end
        check("bp_hit_set", bp_hit, 1);
        check("bp_stop_pulse_same_cycle", run, 1);
        check("bp_pc", pc, 32'h10);
        check("bp_phase_if", cstate, PH_IF);
        settle(10);
        check("bp_stopped", running, 0);
        check("bp_stop_seen", exp_q.size(), 0);

        exp_q.push_back(CMD_RUN);
        press(3'b100, 10);
        resume_cyc = last_pulse_cyc;
        check("resume_seen", exp_q.size(), 0);
        check("bp_hit_cleared", bp_hit, 0);
        exp_q.push_back(CMD_RUN);
        k = 0;
        while (!bp_hit && k < 150) begin @(negedge clock); k++; end
        check("bp_hit_again", bp_hit, 1);
        check("bp_resume_gap_ge60", int'((cyc - resume_cyc) >= 60), 1);
        check("bp_again_pc", pc, 32'h10);
        settle(10);
        check("bp_again_stopped", running, 0);
        bp_en = 1'b0;
        wait_empty("final_queue_empty", 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/panel_ctrl.md
PANEL_CTRL -- requirements
Module: panel_ctrl

Interface
REQ-001 Parameter DB_COUNT, default 16'd50000: consecutive stable cycles required to accept a button level.
REQ-002 Parameter DB_WIDTH, default 16: width of the debounce counter.
REQ-003 Port list, one per line:
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_run  in  1  raw run/stop push button, async, active-high.
- btn_step_inst  in  1  raw one-instruction button, async, active-high.
- btn_step_phase  in  1  raw one-phase button, async, active-high.
- running  in  1  phase generator "executing" status.
- cstate  in  4  one-hot phase: IF=0001, DE=0010, EX=0100, WB=1000.
- pc  in  32  current program counter.
- bp_addr  in  32  breakpoint address.
- bp_en  in  1  breakpoint enable.
- run  out  1  one-cycle pulse; starts or stops continuous run.
- step_inst  out  1  one-cycle pulse; execute one instruction.
- step_phase  out  1  one-cycle pulse; execute one phase.
- bp_hit  out  1  sticky; the last stop was caused by the breakpoint.
- err  out  1  sticky; the phase generator failed to acknowledge a command.

Function
REQ-004 Each button SHALL pass a 2-flop synchronizer, then the debouncer; the debounced level SHALL change only after DB_COUNT consecutive cycles of the new synchronized level.
REQ-005 A 0->1 transition of a debounced level SHALL latch a pending request; the request SHALL clear when issued or discarded.
REQ-006 At most one of run/step_inst/step_phase SHALL be high in any cycle, and each SHALL be high for exactly one cycle per issued command.
REQ-007 Simultaneous pending requests SHALL resolve with priority run > step_inst > step_phase; lower-priority pending requests SHALL be discarded in the same cycle.
REQ-008 FSM states:
- IDLE: running=0 expected.
- ISSUE: drive the selected pulse for 1 cycle.
- CONFIRM: wait for the expected running edge.
- STEP: wait for running=0.
- RUN: running=1.
REQ-009 IDLE: pending run or step -> ISSUE.
REQ-010 RUN: pending run, or a breakpoint match, -> ISSUE with run (stop); step requests in RUN SHALL be discarded.
REQ-011 CONFIRM exits and timeout:
- Start command, running=1 observed -> RUN (run) or STEP (step).
- Stop command, running=0 observed -> IDLE.
- No edge within 3 cycles of the pulse -> set err, then go to RUN if running=1, else IDLE.
REQ-012 STEP: running=0 -> IDLE; all requests arriving during CONFIRM/STEP SHALL be discarded.
REQ-013 A step_phase whose running pulse lasts a single cycle SHALL be accepted as confirmed, and the FSM SHALL return to IDLE.
REQ-014 Breakpoint match definition: state RUN, bp_en=1, cstate==IF, pc==bp_addr, and breakpoint not armed-off.
- On match: set bp_hit the same cycle; issue the stop pulse next cycle.
REQ-015 Breakpoint armed-off rule:
- Issuing any start command SHALL clear bp_hit and set the breakpoint armed-off.
- armed-off SHALL clear on the first cycle cstate!=IF.
- Effect: resuming at a breakpoint address does not stop immediately.
REQ-016 err SHALL clear only on reset.

Reset
REQ-017 On reset=1 at a clock edge, the block SHALL set:
- state=IDLE;
- run=step_inst=step_phase=0;
- bp_hit=0, err=0;
- pending requests cleared, armed-off cleared;
- debounced levels=0, synchronizers=0, counters=0.
REQ-018 Reset asserted mid-command (ISSUE/CONFIRM/STEP/RUN) SHALL abort without emitting any further pulse.

Structure
REQ-019 Shared package panel_pkg SHALL hold:
- phase constants IF/DE/EX/WB;
- FSM state encoding;
- command code enum (NONE/RUN/STEP_INST/STEP_PHASE).
REQ-020 Sub-module btn_debounce (synchronizer + debounce counter + rising-edge output) SHALL be instantiated once per button; all other logic SHALL live in panel_ctrl.

Verification (DB_COUNT=4 and a behavioural phase-generator model in the bench)
REQ-021 Press btn_step_inst for 10 cycles while stopped:
- exactly one step_inst pulse, 6-7 cycles after press (2 sync + 4 debounce + latch);
- FSM returns to IDLE after WB.
REQ-022 Button bouncing 1/0 every 2 cycles for 20 cycles, then held high 10 cycles -> exactly one pulse.
REQ-023 Press btn_run and btn_step_phase in the same cycle -> one run pulse only; step_phase never asserts.
REQ-024 bp_en=1, bp_addr=32'h0000_0010, run started at pc=0:
- bp_hit=1 and a run stop pulse when pc=0x10 in IF;
- next run resumes, with no stop until pc returns to 0x10.
REQ-025 Model ignores a step_inst pulse -> err=1 four cycles after the pulse; FSM in IDLE; a following step_phase is still issued.
REQ-026 Reset asserted in RUN state -> all outputs 0 next cycle; no run pulse emitted.
